// File: rtl/dcache_sram_nway_if.sv
// Bundle between the dcache controller and the N-way storage array:
// access request, registered lookup result and the flush writeback stream.
interface dcache_sram_nway_if #(
  parameter int SETS   = 16,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256
) ();
  localparam int SET_W = $clog2(SETS);

  logic              req_i;
  logic              we_i;
  logic [SET_W-1:0]  set_i;
  logic [TAG_W-1:0]  tag_i;
  logic              dirty_i;
  logic [LINE_W-1:0] data_i;
  logic              ready_o;
  logic              rvalid_o;
  logic              hit_o;
  logic [TAG_W-1:0]  tag_o;
  logic              dirty_o;
  logic [LINE_W-1:0] data_o;
  logic              flush_i;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [SET_W-1:0]  wb_set_o;
  logic [TAG_W-1:0]  wb_tag_o;
  logic [LINE_W-1:0] wb_data_o;
  logic              flush_done_o;

  modport master (
    output req_i, we_i, set_i, tag_i, dirty_i, data_i, flush_i, wb_ready_i,
    input  ready_o, rvalid_o, hit_o, tag_o, dirty_o, data_o,
           wb_valid_o, wb_set_o, wb_tag_o, wb_data_o, flush_done_o
  );

  modport slave (
    input  req_i, we_i, set_i, tag_i, dirty_i, data_i, flush_i, wb_ready_i,
    output ready_o, rvalid_o, hit_o, tag_o, dirty_o, data_o,
           wb_valid_o, wb_set_o, wb_tag_o, wb_data_o, flush_done_o
  );
endinterface

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache storage with true-LRU ages, valid/dirty state and a
// flush engine streaming dirty lines out. Define DCACHE_STATS_EN for hit/miss counters.
module dcache_sram_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256,
  parameter int SET_W  = $clog2(SETS),
  parameter int WAY_W  = $clog2(WAYS)
) (
  input  logic clk_i,
  input  logic rst_ni,
  dcache_sram_nway_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);
  localparam int ENTRIES = SETS * WAYS;
  localparam int IDX_W   = SET_W + WAY_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;
  state_t state_reg;

  // Entry index is {set, way}, so a linear walk of idx visits set-major order.
  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  logic [LINE_W-1:0]  data_mem [ENTRIES];
  logic [ENTRIES-1:0] valid_reg, dirty_reg;
  logic [WAY_W-1:0]   age_reg  [ENTRIES];

  logic [IDX_W-1:0]  idx_reg;
  logic              ready_reg, rvalid_reg, hit_reg, dirty_o_reg;
  logic              wb_valid_reg, flush_done_reg;
  logic [TAG_W-1:0]  tag_o_reg, wb_tag_reg;
  logic [SET_W-1:0]  wb_set_reg;
  logic [LINE_W-1:0] data_o_reg, wb_data_reg;

  logic             accept, scan_dirty, hit_any;
  logic [WAYS-1:0]  hit_vec, inval_vec, oldest_vec;
  logic [WAY_W-1:0] hit_way, free_way, lru_way, sel_way;
  logic [IDX_W-1:0] sel_idx;

  assign accept     = (state_reg == IDLE) && bus.req_i;
  assign scan_dirty = (state_reg == SCAN) && valid_reg[idx_reg] && dirty_reg[idx_reg];

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      localparam logic [WAY_W-1:0] WAY = WAY_W'(gi);
      assign hit_vec[gi]    = valid_reg[{bus.set_i, WAY}] && (tag_mem[{bus.set_i, WAY}] == bus.tag_i);
      assign inval_vec[gi]  = !valid_reg[{bus.set_i, WAY}];
      assign oldest_vec[gi] = age_reg[{bus.set_i, WAY}] == WAY_W'(WAYS - 1);
    end
  endgenerate

  // Descending scan leaves the lowest matching way selected.
  always_comb begin
    hit_way  = '0;
    free_way = '0;
    lru_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w])    hit_way  = WAY_W'(w);
      if (inval_vec[w])  free_way = WAY_W'(w);
      if (oldest_vec[w]) lru_way  = WAY_W'(w);
    end
  end

  assign hit_any = |hit_vec;
  assign sel_way = hit_any ? hit_way : ((|inval_vec) ? free_way : lru_way);
  assign sel_idx = {bus.set_i, sel_way};

  always_ff @(posedge clk_i) begin
    if (accept && bus.we_i) begin
      tag_mem[sel_idx]  <= bus.tag_i;
      data_mem[sel_idx] <= bus.data_i;
    end
  end

  // Read-first: the result registers capture contents before this access's write.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_o_reg  <= '0;
      tag_o_reg   <= '0;
      wb_data_reg <= '0;
      wb_tag_reg  <= '0;
    end else begin
      if (accept) begin
        data_o_reg <= data_mem[sel_idx];
        tag_o_reg  <= tag_mem[sel_idx];
      end
      if (scan_dirty) begin
        wb_data_reg <= data_mem[idx_reg];
        wb_tag_reg  <= tag_mem[idx_reg];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      ready_reg      <= 1'b1;
      rvalid_reg     <= 1'b0;
      hit_reg        <= 1'b0;
      dirty_o_reg    <= 1'b0;
      wb_valid_reg   <= 1'b0;
      wb_set_reg     <= '0;
      flush_done_reg <= 1'b0;
      idx_reg        <= '0;
      valid_reg      <= '0;
      dirty_reg      <= '0;
      for (int e = 0; e < ENTRIES; e++) age_reg[e] <= WAY_W'(e % WAYS);
    end else begin
      rvalid_reg     <= 1'b0;
      flush_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_i) begin
            rvalid_reg  <= 1'b1;
            hit_reg     <= hit_any;
            dirty_o_reg <= valid_reg[sel_idx] & dirty_reg[sel_idx];
            if (bus.we_i) begin
              valid_reg[sel_idx] <= 1'b1;
              dirty_reg[sel_idx] <= bus.dirty_i;
            end
            if (hit_any || bus.we_i) begin
              for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == sel_way)
                  age_reg[{bus.set_i, WAY_W'(w)}] <= '0;
                else if (age_reg[{bus.set_i, WAY_W'(w)}] < age_reg[sel_idx])
                  age_reg[{bus.set_i, WAY_W'(w)}] <= age_reg[{bus.set_i, WAY_W'(w)}] + 1'b1;
              end
            end
          end else if (bus.flush_i) begin
            state_reg <= SCAN;
            ready_reg <= 1'b0;
            idx_reg   <= '0;
          end
        end
        SCAN: begin
          if (scan_dirty) begin
            state_reg    <= WB;
            wb_valid_reg <= 1'b1;
            wb_set_reg   <= idx_reg[IDX_W-1:WAY_W];
          end else if (idx_reg == LAST_IDX) begin
            state_reg      <= DONE;
            flush_done_reg <= 1'b1;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        WB: begin
          if (bus.wb_ready_i) begin
            dirty_reg[idx_reg] <= 1'b0;
            wb_valid_reg       <= 1'b0;
            if (idx_reg == LAST_IDX) begin
              state_reg      <= DONE;
              flush_done_reg <= 1'b1;
            end else begin
              state_reg <= SCAN;
              idx_reg   <= idx_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_o      = ready_reg;
  assign bus.rvalid_o     = rvalid_reg;
  assign bus.hit_o        = hit_reg;
  assign bus.tag_o        = tag_o_reg;
  assign bus.dirty_o      = dirty_o_reg;
  assign bus.data_o       = data_o_reg;
  assign bus.wb_valid_o   = wb_valid_reg;
  assign bus.wb_set_o     = wb_set_reg;
  assign bus.wb_tag_o     = wb_tag_reg;
  assign bus.wb_data_o    = wb_data_reg;
  assign bus.flush_done_o = flush_done_reg;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (rvalid_reg) begin
      if (hit_reg) begin
        if (hit_cnt_reg != '1) hit_cnt_reg <= hit_cnt_reg + 1'b1;
      end else begin
        if (miss_cnt_reg != '1) miss_cnt_reg <= miss_cnt_reg + 1'b1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_reg;
  assign miss_cnt_o = miss_cnt_reg;
`endif
endmodule

// File: tb/tb_dcache_sram_nway.sv
// Scoreboard bench for dcache_sram_nway: a reference cache model queues expected
// lookup results and writebacks, which are popped as the array produces them.
module tb_dcache_sram_nway;
  localparam int WAYS = 4, SETS = 16, TAG_W = 23, LINE_W = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_sram_nway_if #(.SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) bus ();
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_sram_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o (hit_cnt),
    .miss_cnt_o(miss_cnt)
`endif
  );

  typedef struct {
    bit                hit;
    bit                care;
    logic [TAG_W-1:0]  tag;
    bit                dirty;
    logic [LINE_W-1:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]        set;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } wb_t;

  exp_t sb[$];
  wb_t  wbq[$];
  int   n_vec = 0;
  int   n_fail = 0;

  bit                m_valid [SETS][WAYS];
  bit                m_dirty [SETS][WAYS];
  int                m_age   [SETS][WAYS];
  logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
  logic [LINE_W-1:0] m_data  [SETS][WAYS];

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_age[s][w]   = w;
      end
  endtask

  // Reference behaviour: report the pre-access contents, then apply fill/LRU.
  task automatic model_access(input bit we, input int s, input logic [TAG_W-1:0] t,
                              input bit d, input logic [LINE_W-1:0] dat);
    exp_t e;
    int   way = -1;
    int   old_age;
    bit   hit = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) begin way = w; hit = 1'b1; end
    if (!hit)
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
    if (way < 0)
      for (int w = 0; w < WAYS; w++) if (m_age[s][w] == WAYS - 1) way = w;
    e.hit   = hit;
    e.care  = m_valid[s][way];
    e.tag   = m_tag[s][way];
    e.dirty = m_valid[s][way] && m_dirty[s][way];
    e.data  = m_data[s][way];
    sb.push_back(e);
    if (hit || we) begin
      old_age = m_age[s][way];
      for (int w = 0; w < WAYS; w++)
        if (w == way) m_age[s][w] = 0;
        else if (m_age[s][w] < old_age) m_age[s][w]++;
    end
    if (we) begin
      m_valid[s][way] = 1'b1;
      m_dirty[s][way] = d;
      m_tag[s][way]   = t;
      m_data[s][way]  = dat;
    end
  endtask

  task automatic issue(input bit we, input int s, input logic [TAG_W-1:0] t,
                       input bit d, input logic [LINE_W-1:0] dat);
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.set_i   = 4'(s);
    bus.tag_i   = t;
    bus.dirty_i = d;
    bus.data_i  = dat;
    model_access(we, s, t, d, dat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({bus.ready_o, bus.rvalid_o, bus.hit_o, bus.dirty_o, bus.wb_valid_o, bus.flush_done_o} !== 6'b100000 ||
        bus.tag_o !== '0 || bus.data_o !== '0 || bus.wb_set_o !== '0 || bus.wb_tag_o !== '0 || bus.wb_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b rvalid=%b hit=%b dirty=%b wb_valid=%b done=%b tag=%h, want ready=1 others 0",
               bus.ready_o, bus.rvalid_o, bus.hit_o, bus.dirty_o, bus.wb_valid_o, bus.flush_done_o, bus.tag_o);
    end
    rst_n = 1'b1;
    model_reset();
    $display("reset: ready=%b rvalid=%b", bus.ready_o, bus.rvalid_o);
  endtask

  task automatic test_read_miss();
    exp_t e;
    @(negedge clk);
    issue(1'b0, 3, 23'h12, 1'b0, '0);
    @(negedge clk);
    bus.req_i = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (bus.rvalid_o !== 1'b1 || bus.hit_o !== e.hit || bus.dirty_o !== e.dirty || bus.ready_o !== 1'b1 ||
        (e.care && (bus.tag_o !== e.tag || bus.data_o !== e.data))) begin
      n_fail++;
      $display("FAIL read_miss: got rvalid=%b hit=%b dirty=%b ready=%b, want rvalid=1 hit=%b dirty=%b ready=1",
               bus.rvalid_o, bus.hit_o, bus.dirty_o, bus.ready_o, e.hit, e.dirty);
    end
    $display("read set 3 tag 12: rvalid=%b hit=%b dirty=%b", bus.rvalid_o, bus.hit_o, bus.dirty_o);
  endtask

  // Back-to-back writes to one set, then a read of the third line.
  task automatic test_fill();
    logic [TAG_W-1:0] tags [5] = '{23'hA, 23'hB, 23'hC, 23'hD, 23'hC};
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      issue(i < 4, 5, tags[i], 1'b0, rnd_line());
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (bus.rvalid_o !== 1'b1 || bus.hit_o !== e.hit || bus.dirty_o !== e.dirty ||
          (e.care && (bus.tag_o !== e.tag || bus.data_o !== e.data))) begin
        n_fail++;
        $display("FAIL fill[%0d]: got rvalid=%b hit=%b dirty=%b tag=%h data=%h, want hit=%b dirty=%b tag=%h data=%h",
                 i, bus.rvalid_o, bus.hit_o, bus.dirty_o, bus.tag_o, bus.data_o, e.hit, e.dirty, e.tag, e.data);
      end
      $display("fill[%0d] we=%b tag %h: hit=%b tag_o=%h", i, i < 4, tags[i], bus.hit_o, bus.tag_o);
    end
    bus.req_i = 1'b0;
  endtask

  task automatic test_lru();
    logic [TAG_W-1:0] tags [5] = '{23'hA, 23'hE, 23'hB, 23'hA, 23'hE};
    bit               wes  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t e;
`ifdef DCACHE_STATS_EN
    logic [31:0] h0, m0;
    h0 = hit_cnt;
    m0 = miss_cnt;
`endif
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      issue(wes[i], 5, tags[i], 1'b0, rnd_line());
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (bus.rvalid_o !== 1'b1 || bus.hit_o !== e.hit || bus.dirty_o !== e.dirty ||
          (e.care && (bus.tag_o !== e.tag || bus.data_o !== e.data)) || (i == 1 && bus.tag_o !== 23'hB)) begin
        n_fail++;
        $display("FAIL lru[%0d]: got rvalid=%b hit=%b dirty=%b tag=%h, want hit=%b dirty=%b tag=%h",
                 i, bus.rvalid_o, bus.hit_o, bus.dirty_o, bus.tag_o, e.hit, e.dirty, e.tag);
      end
      $display("lru[%0d] we=%b tag %h: hit=%b tag_o=%h", i, wes[i], tags[i], bus.hit_o, bus.tag_o);
    end
    bus.req_i = 1'b0;
    @(negedge clk);
`ifdef DCACHE_STATS_EN
    n_vec++;
    if (hit_cnt - h0 !== 32'd3 || miss_cnt - m0 !== 32'd2) begin
      n_fail++;
      $display("FAIL stats: got hits+%0d misses+%0d, want hits+3 misses+2", hit_cnt - h0, miss_cnt - m0);
    end
    $display("stats: hit_cnt=%0d miss_cnt=%0d", hit_cnt, miss_cnt);
`endif
  endtask

  task automatic test_flush();
    logic [TAG_W-1:0] tags [2] = '{23'h1, 23'h2};
    int   sets [2] = '{0, 15};
    exp_t e;
    wb_t  w;
    int   cnt;
    bit   saw_wb;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, sets[i], tags[i], 1'b1, rnd_line());
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (bus.rvalid_o !== 1'b1 || bus.hit_o !== e.hit || bus.dirty_o !== e.dirty ||
          (e.care && (bus.tag_o !== e.tag || bus.data_o !== e.data))) begin
        n_fail++;
        $display("FAIL dirty_fill[%0d]: got hit=%b dirty=%b, want hit=%b dirty=%b", i, bus.hit_o, bus.dirty_o, e.hit, e.dirty);
      end
      $display("dirty fill set %0d tag %h: hit=%b", sets[i], tags[i], bus.hit_o);
    end
    bus.req_i = 1'b0;
    for (int s = 0; s < SETS; s++)
      for (int wy = 0; wy < WAYS; wy++)
        if (m_valid[s][wy] && m_dirty[s][wy]) begin
          wbq.push_back('{set: 4'(s), tag: m_tag[s][wy], data: m_data[s][wy]});
          m_dirty[s][wy] = 1'b0;
        end
    bus.wb_ready_i = 1'b0;
    bus.flush_i    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b0;
    while (wbq.size() > 0) begin
      w = wbq.pop_front();
      cnt = 0;
      while (bus.wb_valid_o !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
      for (int h = 0; h < 4; h++) begin
        n_vec++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_set_o !== w.set || bus.wb_tag_o !== w.tag ||
            bus.wb_data_o !== w.data || bus.ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL writeback hold %0d: got valid=%b set=%0d tag=%h ready=%b, want valid=1 set=%0d tag=%h ready=0",
                   h, bus.wb_valid_o, bus.wb_set_o, bus.wb_tag_o, bus.ready_o, w.set, w.tag);
        end
        if (h < 3) @(negedge clk);
      end
      $display("writeback set %0d tag %h", bus.wb_set_o, bus.wb_tag_o);
      bus.wb_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.wb_ready_i = 1'b0;
    end
    cnt = 0;
    while (bus.flush_done_o !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
    n_vec++;
    if (bus.flush_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done: got %b after %0d cycles, want 1", bus.flush_done_o, cnt);
    end
    @(negedge clk);
    n_vec++;
    if (bus.flush_done_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done_pulse: got done=%b ready=%b, want done=0 ready=1", bus.flush_done_o, bus.ready_o);
    end
    $display("flush 1 complete");
    // Clean flush: every entry scanned once plus the completion cycle.
    bus.flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b0;
    cnt = 1;
    saw_wb = 1'b0;
    while (bus.flush_done_o !== 1'b1 && cnt < 200) begin
      saw_wb |= bus.wb_valid_o;
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (cnt != SETS * WAYS + 1 || saw_wb) begin
      n_fail++;
      $display("FAIL clean_flush: got %0d cycles wb_seen=%b, want %0d cycles wb_seen=0", cnt, saw_wb, SETS * WAYS + 1);
    end
    $display("flush 2 complete in %0d cycles", cnt);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_flush();
    logic [TAG_W-1:0] tags [4] = '{23'hA, 23'hE, 23'h1, 23'h33};
    int   sets [4] = '{5, 5, 0, 2};
    exp_t e;
    int   cnt;
    bit   bad;
    issue(1'b1, 2, 23'h33, 1'b1, rnd_line());
    @(negedge clk);
    bus.req_i = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (bus.rvalid_o !== 1'b1 || bus.hit_o !== e.hit || bus.dirty_o !== e.dirty) begin
      n_fail++;
      $display("FAIL pre_flush_write: got hit=%b dirty=%b, want hit=%b dirty=%b", bus.hit_o, bus.dirty_o, e.hit, e.dirty);
    end
    bus.flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b0;
    cnt = 0;
    while (bus.wb_valid_o !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
    n_vec++;
    if (bus.wb_valid_o !== 1'b1 || bus.wb_set_o !== 4'd2 || bus.wb_tag_o !== 23'h33) begin
      n_fail++;
      $display("FAIL abort_wb: got valid=%b set=%0d tag=%h, want valid=1 set=2 tag=33", bus.wb_valid_o, bus.wb_set_o, bus.wb_tag_o);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.wb_valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.flush_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: got wb_valid=%b ready=%b done=%b, want 0 1 0", bus.wb_valid_o, bus.ready_o, bus.flush_done_o);
    end
    rst_n = 1'b1;
    model_reset();
    bad = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      bad |= bus.wb_valid_o | bus.flush_done_o | ~bus.ready_o;
    end
    n_vec++;
    if (bad) begin
      n_fail++;
      $display("FAIL abort_quiet: got stray wb_valid/flush_done/not-ready after reset, want none");
    end
    $display("flush aborted by reset");
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, sets[i], tags[i], 1'b0, '0);
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (bus.rvalid_o !== 1'b1 || bus.hit_o !== e.hit || bus.dirty_o !== e.dirty) begin
        n_fail++;
        $display("FAIL post_reset_lookup[%0d]: got rvalid=%b hit=%b dirty=%b, want rvalid=1 hit=%b dirty=%b",
                 i, bus.rvalid_o, bus.hit_o, bus.dirty_o, e.hit, e.dirty);
      end
      $display("post-reset read set %0d tag %h: hit=%b", sets[i], tags[i], bus.hit_o);
    end
    bus.req_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.req_i      = 1'b0;
    bus.we_i       = 1'b0;
    bus.set_i      = '0;
    bus.tag_i      = '0;
    bus.dirty_i    = 1'b0;
    bus.data_i     = '0;
    bus.flush_i    = 1'b0;
    bus.wb_ready_i = 1'b0;
    test_reset();
    test_read_miss();
    test_fill();
    test_lru();
    test_flush();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
